// File: rtl/duck_hunt_pkg.sv
// Shared Duck Hunt constants: screen size, palette, scheduler state and phase encodings.
package duck_hunt_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_GREEN = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_START, S_WAIT} sched_state_t;
  typedef enum logic {PH_ERASE, PH_DRAW} phase_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sprite_select_pe.sv
// Priority encoder: lowest set mask bit at or above i_idx, plus a found flag.
module sprite_select_pe #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_idx,
  output logic [IW-1:0] o_sel,
  output logic          o_found
);
  // Scan high to low so the last hit is the lowest qualifying bit.
  always_comb begin
    o_sel   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i] && (i >= int'(i_idx))) begin
        o_sel   = IW'(i);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// Arbitrates the single-pixel VGA write port among N sprite drawers: ERASE then DRAW per active sprite.
// Optional SPRITE_DRAW_SCHEDULER_CLIP_EN gates vga_plot for off-screen pixels.
module sprite_draw_scheduler
  import duck_hunt_pkg::*;
#(
  parameter int         N         = 3,
  parameter logic [2:0] BG_COLOUR = COL_BLACK,
  parameter int         TIMEOUT   = 255
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic [N-1:0]   sprite_active,
  input  logic [3*N-1:0] sprite_colour,
  input  logic [8*N-1:0] sprite_x,
  input  logic [7*N-1:0] sprite_y,
  input  logic [N-1:0]   sprite_done,
  output logic [N-1:0]   sprite_start,
  output logic           sprite_erase,
  output logic [7:0]     vga_x,
  output logic [6:0]     vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           overrun,
  output logic           timeout_err
);
  localparam int IW = idx_w(N);

  sched_state_t  r_state;
  phase_t        r_phase;
  logic [N-1:0]  r_mask;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_tcnt;
  logic          r_overrun;
  logic          r_tmo_err;

  logic [IW-1:0] w_sel;
  logic          w_found;
  logic          w_wait;
  logic          w_done;
  logic          w_tmo;
  logic          w_on_screen;
  logic [7:0]    w_x;
  logic [6:0]    w_y;
  logic [2:0]    w_col;
  logic [7:0]    w_xs [N];
  logic [6:0]    w_ys [N];
  logic [2:0]    w_cs [N];

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign w_xs[g] = sprite_x[8*g +: 8];
    assign w_ys[g] = sprite_y[7*g +: 7];
    assign w_cs[g] = sprite_colour[3*g +: 3];
  end

  sprite_select_pe #(.N(N), .IW(IW)) u_pe (
    .i_mask  (r_mask),
    .i_idx   (r_idx),
    .o_sel   (w_sel),
    .o_found (w_found)
  );

  assign w_wait = (r_state == S_WAIT);
  assign w_done = sprite_done[r_idx];
  assign w_x    = w_xs[r_idx];
  assign w_y    = w_ys[r_idx];
  assign w_col  = (r_phase == PH_ERASE) ? BG_COLOUR : w_cs[r_idx];
  // Counter holds completed WAIT cycles, so the pass aborts on its TIMEOUT-th WAIT cycle.
  assign w_tmo  = (TIMEOUT != 0) && (r_tcnt == 8'(TIMEOUT - 1));

`ifdef SPRITE_DRAW_SCHEDULER_CLIP_EN
  assign w_on_screen = (w_x < 8'(SCREEN_W)) && (w_y < 7'(SCREEN_H));
`else
  assign w_on_screen = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_phase   <= PH_ERASE;
      r_mask    <= '0;
      r_idx     <= '0;
      r_tcnt    <= '0;
      r_overrun <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      if (frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (frame_tick && (|sprite_active)) begin
            r_mask  <= sprite_active;
            r_idx   <= '0;
            r_phase <= PH_ERASE;
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (w_found) begin
            r_idx   <= w_sel;
            r_state <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_tcnt <= r_tcnt + 8'd1;
          if (w_tmo) r_tmo_err <= 1'b1;
          if (w_done || w_tmo) begin
            if (r_phase == PH_ERASE) begin
              r_phase <= PH_DRAW;
              r_state <= S_START;
            end else begin
              // Index may step past N-1; the cleared mask makes SELECT end the frame.
              r_phase       <= PH_ERASE;
              r_mask[r_idx] <= 1'b0;
              r_idx         <= r_idx + 1'b1;
              r_state       <= S_SELECT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign overrun      = r_overrun;
  assign timeout_err  = r_tmo_err;
  assign sprite_start = (r_state == S_START) ? (N'(1) << r_idx) : '0;
  assign sprite_erase = ((r_state == S_START) || w_wait) && (r_phase == PH_ERASE);
  assign vga_x        = w_wait ? w_x   : 8'd0;
  assign vga_y        = w_wait ? w_y   : 7'd0;
  assign vga_colour   = w_wait ? w_col : 3'd0;
  assign vga_plot     = w_wait && !w_done && !w_tmo && w_on_screen;
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: behavioural drawers plus a frame-level model of expected starts and plots.
module tb_sprite_draw_scheduler;
  localparam int N   = 3;
  localparam int TMO = 20;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic           frame_tick = 1'b0;
  logic [N-1:0]   sprite_active = '0;
  logic [3*N-1:0] sprite_colour;
  logic [8*N-1:0] sprite_x;
  logic [7*N-1:0] sprite_y;
  logic [N-1:0]   sprite_done;
  logic [N-1:0]   sprite_start;
  logic           sprite_erase;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic           overrun;
  logic           timeout_err;

  sprite_draw_scheduler #(.N(N), .BG_COLOUR(3'b000), .TIMEOUT(TMO)) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .sprite_active(sprite_active), .sprite_colour(sprite_colour),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_done(sprite_done),
    .sprite_start(sprite_start), .sprite_erase(sprite_erase),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Drawer models: restart on start pulse, emit L pixels, then hold done (never, if hung).
  int         L    [N] = '{default: 0};
  bit         hang [N] = '{default: 0};
  int         cnt  [N] = '{default: 0};
  logic [2:0] col  [N] = '{default: 3'd0};
  logic [7:0] px   [N][32];
  logic [6:0] py   [N][32];

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (sprite_start[i]) cnt[i] <= 0;
      else if (hang[i] || cnt[i] < L[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  always_comb begin
    sprite_done   = '0;
    sprite_x      = '0;
    sprite_y      = '0;
    sprite_colour = '0;
    for (int i = 0; i < N; i++) begin
      sprite_done[i]        = !hang[i] && (cnt[i] >= L[i]);
      sprite_x[8*i +: 8]    = px[i][cnt[i] % 32];
      sprite_y[7*i +: 7]    = py[i][cnt[i] % 32];
      sprite_colour[3*i +: 3] = col[i];
    end
  end

  typedef struct {int cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c; bit e;} plot_t;
  typedef struct {int cyc; int idx; bit e;} start_t;
  plot_t  qp[$], ep[$];
  start_t qs[$], es[$];
  int     cyc = 0;

  always @(negedge clock) begin
    cyc++;
    if (resetn && vga_plot) qp.push_back('{cyc, vga_x, vga_y, vga_colour, sprite_erase});
    if (resetn) for (int i = 0; i < N; i++)
      if (sprite_start[i]) qs.push_back('{cyc, i, sprite_erase});
  end

  // Frame model: ascending active sprites, ERASE pass in background colour then DRAW pass.
  task automatic build_expect(input logic [N-1:0] mask);
    int n;
    bit ok;
    ep.delete(); es.delete();
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) continue;
      for (int p = 0; p < 2; p++) begin
        es.push_back('{0, i, (p == 0)});
        n = hang[i] ? TMO - 1 : L[i];
        for (int k = 0; k < n; k++) begin
`ifdef SPRITE_DRAW_SCHEDULER_CLIP_EN
          ok = (px[i][k%32] < 160) && (py[i][k%32] < 120);
`else
          ok = 1'b1;
`endif
          if (ok) ep.push_back('{0, px[i][k%32], py[i][k%32], (p == 0) ? 3'd0 : col[i], (p == 0)});
        end
      end
    end
  endtask

  function automatic bit plots_differ(output string s);
    s = "";
    if (qp.size() != ep.size()) begin
      s = $sformatf("plot count got %0d want %0d", qp.size(), ep.size());
      return 1'b1;
    end
    foreach (ep[k])
      if (qp[k].x !== ep[k].x || qp[k].y !== ep[k].y || qp[k].c !== ep[k].c || qp[k].e !== ep[k].e) begin
        s = $sformatf("plot #%0d got (%0d,%0d,c%0d,e%0d) want (%0d,%0d,c%0d,e%0d)", k,
                      qp[k].x, qp[k].y, qp[k].c, qp[k].e, ep[k].x, ep[k].y, ep[k].c, ep[k].e);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit starts_differ(output string s);
    s = "";
    if (qs.size() != es.size()) begin
      s = $sformatf("start count got %0d want %0d", qs.size(), es.size());
      return 1'b1;
    end
    foreach (es[k])
      if (qs[k].idx != es[k].idx || qs[k].e !== es[k].e) begin
        s = $sformatf("start #%0d got (s%0d,e%0d) want (s%0d,e%0d)", k, qs[k].idx, qs[k].e, es[k].idx, es[k].e);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      col[i] = 3'($urandom_range(1, 7));
      for (int k = 0; k < 32; k++) begin
        px[i][k] = 8'($urandom_range(0, 159));
        py[i][k] = 7'($urandom_range(0, 119));
      end
    end
  endtask

  // Pulses frame_tick with mask; optionally re-ticks ovr_at cycles into the first WAIT.
  task automatic run_frame(input logic [N-1:0] mask, input int ovr_at, output bit ended);
    int t;
    build_expect(mask);
    qp.delete(); qs.delete();
    @(negedge clock); sprite_active = mask; frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0; sprite_active = N'($urandom);
    if (ovr_at >= 0) begin
      t = 0;
      while (!vga_plot && t < 200) begin @(negedge clock); t++; end
      repeat (ovr_at) @(negedge clock);
      frame_tick = 1'b1; @(negedge clock); frame_tick = 1'b0;
    end
    ended = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!busy) begin ended = 1'b1; break; end
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    repeat (3) @(negedge clock);
    outs = {busy, overrun, timeout_err, sprite_start, sprite_erase, vga_plot, vga_x, vga_y, vga_colour};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_hold outs=%h want 0", outs); end
    resetn = 1'b1;
    @(negedge clock);
    outs = {busy, overrun, timeout_err, sprite_start, sprite_erase, vga_plot, vga_x, vga_y, vga_colour};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_release outs=%h want 0", outs); end
    sprite_active = '0; frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || qs.size() != 0) begin
      failures++; $display("FAIL empty_mask busy=%b starts=%0d want 0/0", busy, qs.size());
    end
  endtask

  task automatic test_two_sprites();
    bit ended; string s;
    fill_random(); L[0] = 4; L[1] = 6; L[2] = 9;
    run_frame(3'b011, -1, ended);
    checks++; if (!ended) begin failures++; $display("FAIL two_end busy=%b want 0", busy); end
    checks++; if (starts_differ(s)) begin failures++; $display("FAIL two_starts %s", s); end
    checks++; if (qp.size() != 20) begin failures++; $display("FAIL two_plot_count got %0d want 20", qp.size()); end
    checks++; if (plots_differ(s)) begin failures++; $display("FAIL two_plots %s", s); end
    checks++;
    foreach (qs[k]) if (qs[k].idx == 2) begin failures++; $display("FAIL two_no_s2 got start of sprite 2 want none"); break; end
  endtask

  task automatic test_latency();
    bit ended; string s;
    fill_random(); L[2] = 13; px[2][0] = 8'd10; py[2][0] = 7'd7;
    run_frame(3'b100, -1, ended);
    checks++;
    if (qp.size() == 0 || qs.size() == 0 || qp[0].x !== 8'd10 || qp[0].y !== 7'd7 || qp[0].cyc != qs[0].cyc + 1) begin
      failures++;
      $display("FAIL lat_first got %0d plots first=(%0d,%0d)@%0d start@%0d want (10,7)@start+1",
               qp.size(), (qp.size() > 0) ? qp[0].x : 0, (qp.size() > 0) ? qp[0].y : 0,
               (qp.size() > 0) ? qp[0].cyc : -1, (qs.size() > 0) ? qs[0].cyc : -1);
    end
    checks++; if (qp.size() != 26) begin failures++; $display("FAIL lat_count got %0d want 26", qp.size()); end
    checks++; if (plots_differ(s) || !ended) begin failures++; $display("FAIL lat_plots end=%b %s", ended, s); end
  endtask

  task automatic test_random();
    bit ended; string s;
    logic [N-1:0] m;
    for (int f = 0; f < 6; f++) begin
      fill_random();
      for (int i = 0; i < N; i++) L[i] = $urandom_range(1, 15);
      m = N'($urandom_range(1, 7));
      run_frame(m, -1, ended);
      checks++; if (!ended) begin failures++; $display("FAIL rnd%0d_end busy=%b want 0", f, busy); end
      checks++; if (starts_differ(s)) begin failures++; $display("FAIL rnd%0d_starts mask=%b %s", f, m, s); end
      checks++; if (plots_differ(s)) begin failures++; $display("FAIL rnd%0d_plots mask=%b %s", f, m, s); end
    end
    checks++; if (overrun !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL rnd_sticky ovr=%b tmo=%b want 0/0", overrun, timeout_err);
    end
  endtask

  task automatic test_overrun();
    bit ended; string s;
    fill_random(); L[0] = 12;
    run_frame(3'b001, 5, ended);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got %b want 1", overrun); end
    checks++; if (starts_differ(s) || !ended) begin failures++; $display("FAIL ovr_starts end=%b %s", ended, s); end
    checks++; if (plots_differ(s)) begin failures++; $display("FAIL ovr_plots %s", s); end
    repeat (20) @(negedge clock);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0 || qs.size() != 2) begin
      failures++; $display("FAIL ovr_hold ovr=%b busy=%b starts=%0d want 1/0/2", overrun, busy, qs.size());
    end
  endtask

  task automatic test_timeout();
    bit ended; string s;
    fill_random(); L[0] = 5; L[2] = 7; hang[1] = 1'b1;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_pre got %b want 0", timeout_err); end
    run_frame(3'b111, -1, ended);
    hang[1] = 1'b0;
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_set got %b want 1", timeout_err); end
    checks++; if (starts_differ(s) || !ended) begin failures++; $display("FAIL tmo_starts end=%b %s", ended, s); end
    checks++; if (plots_differ(s)) begin failures++; $display("FAIL tmo_plots %s", s); end
  endtask

  task automatic test_midreset();
    bit ended; string s;
    int t;
    logic [31:0] outs;
    fill_random(); L[0] = 10;
    qs.delete();
    @(negedge clock); sprite_active = 3'b001; frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    t = 0;
    while (!(vga_plot && !sprite_erase) && t < 200) begin @(negedge clock); t++; end
    checks++; if (t >= 200) begin failures++; $display("FAIL mrst_reach no DRAW plot within 200 cycles"); end
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    #1;
    outs = {busy, overrun, timeout_err, sprite_start, sprite_erase, vga_plot, vga_x, vga_y, vga_colour};
    checks++; if (outs !== '0) begin failures++; $display("FAIL mrst_zero outs=%h want 0", outs); end
    @(negedge clock); resetn = 1'b1;
    @(negedge clock);
    run_frame(3'b001, -1, ended);
    checks++;
    if (qs.size() == 0 || qs[0].idx != 0 || qs[0].e !== 1'b1) begin
      failures++; $display("FAIL mrst_first got %0d starts first_e=%b want sprite0 erase", qs.size(),
                           (qs.size() > 0) ? qs[0].e : 1'b0);
    end
    checks++; if (starts_differ(s) || plots_differ(s) || !ended) begin failures++; $display("FAIL mrst_frame end=%b %s", ended, s); end
  endtask

  task automatic test_clip();
    bit ended; string s;
    int want;
    fill_random(); L[0] = 2;
    px[0][0] = 8'd255; py[0][0] = 7'd127;
    px[0][1] = 8'd159; py[0][1] = 7'd119;
`ifdef SPRITE_DRAW_SCHEDULER_CLIP_EN
    want = 2;
`else
    want = 4;
`endif
    run_frame(3'b001, -1, ended);
    checks++; if (qp.size() != want) begin failures++; $display("FAIL clip_count got %0d want %0d", qp.size(), want); end
    checks++; if (plots_differ(s) || !ended) begin failures++; $display("FAIL clip_plots end=%b %s", ended, s); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) for (int k = 0; k < 32; k++) begin px[i][k] = '0; py[i][k] = '0; end
    test_reset();
    test_two_sprites();
    test_latency();
    test_random();
    test_overrun();
    test_timeout();
    test_midreset();
    test_clip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Sequences the shared single-pixel VGA write port among N sprite drawers (birds, hunter, laser).
- On each frame tick, walks sprites 0..N-1 in order. For each active sprite it runs an ERASE pass (background colour) and then a DRAW pass (sprite colour).
- Sits between the per-sprite drawers and vga_adapter; replaces hand-written per-sprite ERASE/DRAW states in the top level.

Parameters:
- N, 3, number of sprite requesters (1..8).
- BG_COLOUR, 3'b000, colour driven during ERASE passes.
- TIMEOUT, 255, max WAIT cycles per pass before abort (8-bit counter; 0 disables).

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame (frame_counter q)
- sprite_active  in  N  bit i=1: sprite i is serviced this frame; sampled in IDLE on frame_tick
- sprite_colour  in  3*N  draw colour of sprite i, bits [3i+2:3i]
- sprite_x  in  8*N  current pixel x from drawer i
- sprite_y  in  7*N  current pixel y from drawer i
- sprite_done  in  N  drawer i finished its pixel list
- sprite_start  out  N  one-hot, one-cycle restart pulse to drawer i
- sprite_erase  out  1  1 during ERASE pass (drawer uses previous position)
- vga_x  out  8  pixel x to vga_adapter
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write enable
- busy  out  1  1 outside IDLE
- overrun  out  1  sticky: frame_tick arrived while busy
- timeout_err  out  1  sticky: a pass was aborted by TIMEOUT

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0; index=0, phase=ERASE, active mask=0, timeout counter=0.
- States: IDLE, SELECT, START, WAIT.
- IDLE: on frame_tick, latch sprite_active into mask, index=0, phase=ERASE, go to SELECT. If the mask is all zero, stay in IDLE (busy stays 0).
- SELECT (1 cycle): finds the lowest set mask bit at or above index.
  - If found, set index to it and go to START.
  - If none, go to IDLE.
- START (1 cycle):
  - sprite_start[index]=1; sprite_erase=(phase==ERASE); vga_plot=0.
  - sprite_done is ignored in this cycle. Clear the timeout counter.
- WAIT:
  - vga_x/vga_y = sprite_x/sprite_y slice [index], passed through combinationally (zero latency).
  - vga_colour = BG_COLOUR in ERASE, else sprite_colour[index]. vga_plot = ~sprite_done[index].
  - When sprite_done[index]=1 (vga_plot=0 that cycle):
    - If phase was ERASE: set phase=DRAW and go to START.
    - Otherwise: set phase=ERASE, clear mask[index], index+1, go to SELECT.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT: set timeout_err and treat as done. vga_plot=0 on the abort cycle.
- sprite_erase holds through START and WAIT of an ERASE pass; it is 0 elsewhere.
- Outputs vga_x/vga_y/vga_colour are 0 in IDLE, SELECT and START.
- frame_tick while busy: the tick is dropped and overrun is set. Overrun clears only on resetn.
- frame_tick in the same cycle as the return to IDLE: the tick is dropped and overrun is set (busy is still 1 that cycle).
- sprite_active changes mid-frame have no effect until the next IDLE sample.
- Reset mid-pass: immediate abort to IDLE. sprite_start is not pulsed. The next frame re-runs ERASE normally.
- Index arithmetic: index width is clog2(N) with a minimum of 1. SELECT never wraps. Index+1 from N-1 ends the frame.

Optional Feature:
- Macro: SPRITE_DRAW_SCHEDULER_CLIP_EN.
- Defined:
  - vga_plot is additionally gated off when vga_x≥160 or vga_y≥120. Covers drawer defaults of -1 and sprites partly off-screen.
  - A clipped pixel does not affect sequencing.
- Undefined: no coordinate check; out-of-range pixels are passed to vga_adapter unchanged.

Decomposition:
- Shared package duck_hunt_pkg holds:
  - screen constants SCREEN_W=160, SCREEN_H=120;
  - colour constants COL_BLACK=3'b000, COL_WHITE=3'b111, COL_BLUE=3'b001, COL_GREEN=3'b010;
  - state encoding for IDLE, SELECT, START, WAIT;
  - phase enum ERASE/DRAW.
- One sub-module: sprite_select_pe, a combinational priority encoder that returns the lowest set bit ≥ index plus a found flag. Everything else stays in one module.

Test Plan (N=3 unless noted):
- Mask=3'b011, drawers finish after 4 and 6 pixels. frame_tick → start pulses in order 0(E),0(D),1(E),1(D). Exactly 20 vga_plot cycles total. ERASE colour is 000; DRAW uses sprite_colour. busy returns to 0 and sprite 2 is never started.
- Mask=3'b100, drawer 2 with a 13-pixel list at x=10, y=7 → first plotted pixel is (10,7) at the cycle after START. 13 plots erase plus 13 plots draw.
- frame_tick pulsed again 5 cycles into the first WAIT → overrun=1 and stays 1. The second tick causes no restart.
- Drawer 1 never asserts done, TIMEOUT=20 → abort after 20 WAIT cycles and timeout_err=1. The scheduler proceeds to sprite 1 DRAW, then sprite 2.
- resetn pulsed low during sprite 0 DRAW WAIT → all outputs 0 immediately. After release, the next frame_tick starts from sprite 0 ERASE.
- With SPRITE_DRAW_SCHEDULER_CLIP_EN, drawer emits (255,127) and (159,119) → vga_plot is 0 for the first pixel and 1 for the second. Without the macro, both are plotted.
